sa_result_drain: RTL and testbench
==================================

# sa_result_drain

Output stage for the systolic multiplier. When the array's run-complete flag rises, the block captures the N×N result matrix (16-bit per element) into a local register bank. It then streams the elements out one per handshake in row-major order over a valid/ready interface. Each frame carries row/column tags, a last marker and a running 16-bit checksum, which frees the array for the next run while results drain to the host link.

## Interface
- N, 8, array dimension; frame length N*N elements
- W, 16, element width in bits
- clk  in  1  single clock for the whole block; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- done  in  1  run-complete level from the multiplier; high once the C matrix is stable
- c_flat  in  N*N*W  result matrix, element (r,c) at bits [(r*N+c)*W +: W]
- out_data  out  W  current element
- out_row  out  3  row index of out_data (log2 N bits)
- out_col  out  3  column index of out_data
- out_valid  out  1  out_data/out_row/out_col/out_last are valid
- out_ready  in  1  consumer accepts the element on this edge when out_valid=1
- out_last  out  1  high with element (N-1,N-1)
- busy  out  1  high while a frame is held or streaming
- frame_done  out  1  one-cycle pulse after the last handshake
- checksum  out  W  modulo-2^W sum of all elements transferred in the current/last frame
- missed  out  1  sticky; a done rising edge arrived while busy

## Operation
- States: IDLE, STREAM.
- done_q is a registered copy of done, reset to 0. Rising edge = done & ~done_q.
- IDLE:
  - On a rising edge: copy all of c_flat into the bank, set idx=0, clear checksum to 0, go to STREAM.
  - done held high does not re-trigger.
- STREAM:
  - out_valid=1, and out_data = bank[idx].
  - out_row = idx / N, out_col = idx % N, out_last = (idx == N*N-1).
  - On an edge with out_ready=1:
    - checksum <= checksum + out_data, truncated to W bits.
    - If idx < N*N-1: idx increments.
    - Otherwise: go to IDLE and pulse frame_done.
  - With out_ready=0: all outputs are held stable. No dropping and no reordering.
- busy = (state == STREAM).
- A rising edge of done while in STREAM is ignored:
  - the bank is not overwritten;
  - missed is set and stays set until reset.
- If the last handshake and a rising edge of done fall on the same edge:
  - the frame completes and frame_done pulses;
  - the edge counts as arriving while busy, so missed sets and there is no capture.
- After IDLE, checksum holds its final value until the next capture clears it.
- c_flat is sampled only on the capture edge; later changes on c_flat do not affect the frame.

## Timing
- Reset values (asserted asynchronously when rst=0): state=IDLE, idx=0, out_valid=0, out_last=0, out_data=0, out_row=0, out_col=0, busy=0, frame_done=0, checksum=0, missed=0, done_q=0, bank=0.
- Capture latency:
  - done is first sampled high at edge k.
  - out_valid=1 with element (0,0) is visible after edge k, so the first handshake can occur at edge k+1.
- Throughput: one element per cycle when out_ready is held high. A full frame takes N*N=64 handshake edges, k+1 through k+64.
- frame_done is high for exactly the cycle following the final handshake edge; out_valid is 0 in that cycle.
- If done is already high at the first edge after reset is released, a capture occurs, because done_q resets to 0.
- Reset asserted mid-frame: the frame is abandoned immediately and nothing more is emitted until a new done rising edge is seen after reset.
- done is assumed synchronous to clk; no synchronizer is included.

## Test plan
- Basic frame: c_flat element (r,c) = r*16+c, done pulse, out_ready=1 always.
  - Expect 64 beats in row-major order: (0,0)=0 … (7,7)=119.
  - out_last only on beat 64; frame_done one cycle later.
  - checksum = 3808 (0x0EE0).
- Backpressure: same data, out_ready toggles 1,0,0,1,…
  - While ready=0, out_data/out_row/out_col are held.
  - Element sequence is unchanged; checksum = 0x0EE0.
- Checksum wrap: all elements 0xFFFF → checksum = 64*0xFFFF mod 2^16 = 0xFFC0. Each out_data = 0xFFFF.
- Overrun:
  - done falls, then rises again at beat 10 of a frame, with c_flat changed.
  - Current frame is unaffected and completes with the original data; missed=1; no second frame starts.
- Held done: done stays high for 200 cycles → exactly one frame and one frame_done pulse.
- Reset mid-stream: rst=0 at beat 20.
  - All outputs go to reset values immediately, with missed=0.
  - After release with done low, then a done rising edge: a fresh frame starts at (0,0) with checksum restarted from 0.

Source files
------------

// File: rtl/sa_result_drain_if.sv
// Result stream from the drain stage: one matrix element per valid/ready beat.
// Carries the element, its row/column tags and an end-of-frame marker.
// The producer holds every field stable while valid is high and ready is low.
interface sa_result_drain_if #(
  parameter int W  = 16,
  parameter int IW = 3
);
  logic [W-1:0]  out_data;
  logic [IW-1:0] out_row;
  logic [IW-1:0] out_col;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  modport master (
    output out_data, out_row, out_col, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  out_data, out_row, out_col, out_valid, out_last,
    output out_ready
  );
endinterface

// File: rtl/sa_result_drain.sv
// Captures the systolic array's NxN result on a done rising edge and streams it row-major.
// Latency: first element is valid the cycle after done is first sampled high; one element per cycle.
// Backpressure: with ready low every output field holds; nothing is dropped or reordered.
module sa_result_drain #(
  parameter int N = 8,
  parameter int W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               done,
  input  logic [N*N*W-1:0]   c_flat,
  sa_result_drain_if.master  res,
  output logic               busy,
  output logic               frame_done,
  output logic [W-1:0]       checksum,
  output logic               missed
);
  localparam int NE = N * N;
  localparam int IW = $clog2(N);
  localparam int XW = $clog2(NE);
  localparam logic [XW-1:0] LAST_IDX = XW'(NE - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t         state;
  logic [XW-1:0]  idx;
  logic           done_q;
  logic [W-1:0]   bank [NE];

  logic           rise;
  logic [XW-1:0]  nxt;

  // Edge detect on done and the index of the element that follows the current one.
  always_comb begin
    rise = done & ~done_q;
    nxt  = idx + 1'b1;
  end

  // Capture/stream FSM; all stream outputs are registered so they stay put under backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      idx           <= '0;
      done_q        <= 1'b0;
      res.out_data  <= '0;
      res.out_row   <= '0;
      res.out_col   <= '0;
      res.out_valid <= 1'b0;
      res.out_last  <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      checksum      <= '0;
      missed        <= 1'b0;
      for (int i = 0; i < NE; i++) begin
        bank[i] <= '0;
      end
    end else begin
      done_q     <= done;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            for (int i = 0; i < NE; i++) begin
              bank[i] <= c_flat[i*W +: W];
            end
            idx           <= '0;
            checksum      <= '0;
            res.out_data  <= c_flat[W-1:0];
            res.out_row   <= '0;
            res.out_col   <= '0;
            res.out_last  <= (NE == 1);
            res.out_valid <= 1'b1;
            busy          <= 1'b1;
            state         <= STREAM;
          end
        end
        STREAM: begin
          // A new result while the bank is still draining is dropped and flagged.
          if (rise) begin
            missed <= 1'b1;
          end
          if (res.out_ready) begin
            checksum <= checksum + res.out_data;
            if (idx != LAST_IDX) begin
              idx          <= nxt;
              res.out_data <= bank[nxt];
              res.out_row  <= nxt[XW-1:IW];
              res.out_col  <= nxt[IW-1:0];
              res.out_last <= (nxt == LAST_IDX);
            end else begin
              res.out_valid <= 1'b0;
              res.out_last  <= 1'b0;
              busy          <= 1'b0;
              frame_done    <= 1'b1;
              state         <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sa_result_drain.sv
// Randomized bench for sa_result_drain with a queue-based reference model.
// Model is updated once per cycle on the falling edge from the inputs the next rising edge will see.
// Ready is driven by a separate process in one of three patterns: always, 1-0-0 repeating, random.
module tb_sa_result_drain;
  localparam int N  = 8;
  localparam int W  = 16;
  localparam int NE = N * N;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              done = 1'b0;
  logic [NE*W-1:0]   c_flat = '0;
  logic              busy;
  logic              frame_done;
  logic [W-1:0]      checksum;
  logic              missed;

  sa_result_drain_if #(.W(W), .IW(3)) res ();

  sa_result_drain #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .done       (done),
    .c_flat     (c_flat),
    .res        (res),
    .busy       (busy),
    .frame_done (frame_done),
    .checksum   (checksum),
    .missed     (missed)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: the frame is a queue of pending elements; the sum is plain arithmetic.
  logic [W-1:0] exp_q [$];
  int           beat = 0;
  logic [W-1:0] m_sum = '0;
  bit           m_missed = 1'b0;
  bit           m_fd = 1'b0;
  bit           prev_done = 1'b0;
  int           fd_count = 0;

  int rdy_mode  = 0;
  int rdy_phase = 0;

  // Ready pattern generator, changes just after each rising edge.
  always @(posedge clk) begin
    #1;
    rdy_phase++;
    case (rdy_mode)
      0:       res.out_ready = 1'b1;
      1:       res.out_ready = (rdy_phase % 3 == 0);
      default: res.out_ready = ($urandom_range(0, 9) < 7);
    endcase
  end

  // Compare outputs against the model, then advance the model across the coming edge.
  always @(negedge clk) begin
    bit hs;
    bit was_busy;
    bit rise;
    if (!rst) begin
      chk_eq("rst_valid", res.out_valid, 0);
      chk_eq("rst_busy", busy, 0);
      chk_eq("rst_fd", frame_done, 0);
      chk_eq("rst_cksum", checksum, 0);
      chk_eq("rst_missed", missed, 0);
      chk_eq("rst_data", res.out_data, 0);
      chk_eq("rst_row", res.out_row, 0);
      chk_eq("rst_col", res.out_col, 0);
      chk_eq("rst_last", res.out_last, 0);
      exp_q.delete();
      beat = 0; m_sum = '0; m_missed = 0; m_fd = 0; prev_done = 0;
    end else begin
      was_busy = (exp_q.size() > 0);
      chk_eq("valid", res.out_valid, was_busy);
      chk_eq("busy", busy, was_busy);
      chk_eq("frame_done", frame_done, m_fd);
      chk_eq("checksum", checksum, m_sum);
      chk_eq("missed", missed, m_missed);
      if (frame_done === 1'b1) fd_count++;
      if (was_busy) begin
        chk_eq("data", res.out_data, exp_q[0]);
        chk_eq("row", res.out_row, beat / N);
        chk_eq("col", res.out_col, beat % N);
        chk_eq("last", res.out_last, (beat == NE - 1));
      end
      hs   = was_busy && (res.out_ready === 1'b1);
      rise = done && !prev_done;
      m_fd = 0;
      if (hs) begin
        m_sum = m_sum + exp_q.pop_front();
        beat++;
        if (exp_q.size() == 0) m_fd = 1;
      end
      if (rise) begin
        if (was_busy) m_missed = 1;
        else begin
          for (int i = 0; i < NE; i++) exp_q.push_back(c_flat[i*W +: W]);
          beat = 0;
          m_sum = '0;
        end
      end
      prev_done = done;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill(input int kind);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        case (kind)
          0:       c_flat[(r*N+c)*W +: W] = W'(r * 16 + c);
          1:       c_flat[(r*N+c)*W +: W] = 16'hFFFF;
          default: c_flat[(r*N+c)*W +: W] = W'($urandom);
        endcase
  endtask

  task automatic pulse_done();
    cyc(1); done = 1'b1;
    cyc(1); done = 1'b0;
  endtask

  task automatic do_reset();
    cyc(1); rst = 1'b0;
    cyc(2); rst = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin cyc(1); k++; end
    chk_eq("drain_timeout", exp_q.size(), 0);
    cyc(3);
  endtask

  task automatic wait_beat(input int n);
    int k = 0;
    while (beat < n && k < 1000) begin cyc(1); k++; end
    chk_eq("beat_timeout", (beat >= n), 1);
  endtask

  initial begin
    int fd0;
    int k;
    res.out_ready = 1'b0;
    cyc(3);
    rst = 1'b1;
    cyc(2);

    // Basic frame, ready always high.
    fill(0); rdy_mode = 0; fd0 = fd_count;
    pulse_done(); wait_idle(300);
    chk_eq("basic_cksum", checksum, 16'h0EE0);
    chk_eq("basic_fd_cnt", fd_count - fd0, 1);

    // Backpressure 1,0,0 repeating.
    rdy_mode = 1; fd0 = fd_count;
    pulse_done(); wait_idle(600);
    chk_eq("bp_cksum", checksum, 16'h0EE0);
    chk_eq("bp_fd_cnt", fd_count - fd0, 1);

    // Checksum wrap.
    fill(1); rdy_mode = 2;
    pulse_done(); wait_idle(600);
    chk_eq("wrap_cksum", checksum, 16'hFFC0);

    // Overrun at beat 10 with new data on c_flat.
    fill(2); fd0 = fd_count;
    pulse_done(); wait_beat(10);
    fill(2); done = 1'b1;
    wait_idle(600);
    done = 1'b0; cyc(5);
    chk_eq("ovr_missed", missed, 1);
    chk_eq("ovr_idle", busy, 0);
    chk_eq("ovr_fd_cnt", fd_count - fd0, 1);

    // Done held high for 200 cycles.
    do_reset(); fill(2); fd0 = fd_count;
    cyc(1); done = 1'b1;
    cyc(200); done = 1'b0;
    wait_idle(600);
    chk_eq("held_fd_cnt", fd_count - fd0, 1);

    // Reset mid-stream clears missed and abandons the frame.
    fill(2); pulse_done(); wait_beat(5);
    done = 1'b1; cyc(1); done = 1'b0;
    wait_beat(20);
    chk_eq("pre_rst_missed", missed, 1);
    rst = 1'b0; cyc(2); rst = 1'b1; cyc(4);
    chk_eq("post_rst_idle", busy, 0);
    fill(2); pulse_done(); wait_idle(600);
    chk_eq("post_rst_cksum", checksum, m_sum);

    // Last handshake and done rising edge on the same edge.
    fill(2); rdy_mode = 0; fd0 = fd_count;
    pulse_done();
    k = 0;
    while (exp_q.size() != 1 && k < 500) begin cyc(1); k++; end
    chk_eq("last_wait", exp_q.size(), 1);
    done = 1'b1;
    wait_idle(100);
    done = 1'b0;
    chk_eq("same_edge_missed", missed, 1);
    chk_eq("same_edge_fd_cnt", fd_count - fd0, 1);
    chk_eq("same_edge_idle", busy, 0);

    // Done already high when reset is released.
    cyc(1); rst = 1'b0; fill(2); done = 1'b1;
    cyc(2); rst = 1'b1;
    cyc(2);
    chk_eq("cap_after_rst", busy, 1);
    wait_idle(600); done = 1'b0;

    // A few random frames with random ready and random gaps.
    rdy_mode = 2;
    for (int f = 0; f < 4; f++) begin
      fill(2); cyc($urandom_range(1, 5));
      pulse_done(); wait_idle(600);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
